// File: rtl/nds_window_scanout.sv
// Raster timing generator with a windowed, integer-upscaled frame-buffer scan-out.
// Counter-side sync/position info is delayed BRAM_LAT+1 cycles so every output describes the same pixel.
module nds_window_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int SRC_W    = 256,
  parameter int SRC_H    = 192,
  parameter int SCALE    = 1,
  parameter int WIN_X0   = 192,
  parameter int WIN_Y0   = 144,
  parameter int PIX_W    = 18,
  parameter int BRAM_LAT = 2,
  parameter int ADDR_W   = 16
) (
  input  logic              pixel_clk,
  input  logic              reset,
  input  logic [PIX_W-1:0]  border_rgb,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_en,
  input  logic [PIX_W-1:0]  bram_data,
  output logic              hs,
  output logic              vs,
  output logic              active_nblank,
  output logic [9:0]        draw_x,
  output logic [9:0]        draw_y,
  output logic [5:0]        red,
  output logic [5:0]        green,
  output logic [5:0]        blue,
  output logic              frame_start
);

  localparam int CW    = 12;
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int SX_W  = $clog2(SRC_W + 1);
  localparam int SY_W  = $clog2(SRC_H + 1);
  localparam int SUB_W = 2;

  localparam logic [CW-1:0] H_LAST  = CW'(H_TOT - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOT - 1);
  localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LEN  = CW'(H_SYNC);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LEN  = CW'(V_SYNC);
  localparam logic [CW-1:0] WX_BEG  = CW'(WIN_X0);
  localparam logic [CW-1:0] WX_LEN  = CW'(SRC_W * SCALE);
  localparam logic [CW-1:0] WY_BEG  = CW'(WIN_Y0);
  localparam logic [CW-1:0] WY_LEN  = CW'(SRC_H * SCALE);

  localparam logic [SUB_W-1:0]  SCALE_LAST = SUB_W'(SCALE - 1);
  localparam logic [SX_W-1:0]   SX_MAX     = SX_W'(SRC_W);
  localparam logic [SY_W-1:0]   SY_MAX     = SY_W'(SRC_H);
  localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(SRC_W);

  typedef struct packed {
    logic       fs;
    logic       win;
    logic       act;
    logic       vs;
    logic       hs;
    logic [9:0] dy;
    logic [9:0] dx;
  } pix_info_t;

  localparam pix_info_t RST_INFO = '{1'b0, 1'b0, 1'b0, ~VS_POL, ~HS_POL, 10'd0, 10'd0};

  logic [CW-1:0]     hc_r, vc_r;
  logic [SX_W-1:0]   sx_r;
  logic [SY_W-1:0]   sy_r;
  logic [SUB_W-1:0]  sub_x_r, sub_y_r;
  logic [ADDR_W-1:0] row_base_r;
  logic [ADDR_W-1:0] bram_addr_r;
  logic              bram_en_r;
  pix_info_t         pipe_r [0:BRAM_LAT];

  logic              line_end_s, frame_end_s, x_in_s, y_in_s, win_s;
  logic [ADDR_W-1:0] addr_s;
  pix_info_t         stage_s;
  pix_info_t         out_s;
  logic [PIX_W-1:0]  rgb_s;

  // Raster position counters.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      hc_r <= '0;
      vc_r <= '0;
    end else if (hc_r == H_LAST) begin
      hc_r <= '0;
      vc_r <= (vc_r == V_LAST) ? '0 : vc_r + CW'(1);
    end else begin
      hc_r <= hc_r + CW'(1);
    end
  end

  // Window membership and source address for the pixel at the counters.
  always_comb begin
    line_end_s  = (hc_r == H_LAST);
    frame_end_s = line_end_s && (vc_r == V_LAST);
    // Unsigned wrap makes positions left of / above the window compare as out of range.
    x_in_s      = ((hc_r - WX_BEG) < WX_LEN);
    y_in_s      = ((vc_r - WY_BEG) < WY_LEN);
    win_s       = x_in_s && y_in_s && (sx_r < SX_MAX) && (sy_r < SY_MAX);
    addr_s      = row_base_r + ADDR_W'(sx_r);
  end

  // Source-coordinate stepping: sx every SCALE pixels, sy/row_base every SCALE window lines.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      sx_r       <= '0;
      sub_x_r    <= '0;
      sy_r       <= '0;
      sub_y_r    <= '0;
      row_base_r <= '0;
    end else begin
      if (line_end_s) begin
        sx_r    <= '0;
        sub_x_r <= '0;
      end else if (x_in_s) begin
        if (sub_x_r == SCALE_LAST) begin
          sub_x_r <= '0;
          sx_r    <= sx_r + SX_W'(1);
        end else begin
          sub_x_r <= sub_x_r + SUB_W'(1);
        end
      end
      if (frame_end_s) begin
        sy_r       <= '0;
        sub_y_r    <= '0;
        row_base_r <= '0;
      end else if (line_end_s && y_in_s) begin
        if (sub_y_r == SCALE_LAST) begin
          sub_y_r    <= '0;
          sy_r       <= sy_r + SY_W'(1);
          row_base_r <= row_base_r + ROW_STEP;
        end else begin
          sub_y_r <= sub_y_r + SUB_W'(1);
        end
      end
    end
  end

  // BRAM request; the address holds while disabled so it never goes X.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      bram_en_r   <= 1'b0;
      bram_addr_r <= '0;
    end else begin
      bram_en_r <= win_s;
      if (win_s) begin
        bram_addr_r <= addr_s;
      end
    end
  end

  // Per-pixel info captured alongside the BRAM request.
  always_comb begin
    stage_s     = RST_INFO;
    stage_s.dx  = hc_r[9:0];
    stage_s.dy  = vc_r[9:0];
    stage_s.hs  = ((hc_r - HS_BEG) < HS_LEN) ? HS_POL : ~HS_POL;
    stage_s.vs  = ((vc_r - VS_BEG) < VS_LEN) ? VS_POL : ~VS_POL;
    stage_s.act = (hc_r < H_ACT) && (vc_r < V_ACT);
    stage_s.win = win_s;
    stage_s.fs  = (hc_r == '0) && (vc_r == '0);
  end

  // Alignment pipeline matching the BRAM read latency.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= BRAM_LAT; i++) begin
        pipe_r[i] <= RST_INFO;
      end
    end else begin
      pipe_r[0] <= stage_s;
      for (int i = 1; i <= BRAM_LAT; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  // Colour select for the aligned pixel.
  always_comb begin
    out_s = pipe_r[BRAM_LAT];
    rgb_s = '0;
    if (out_s.win) begin
      rgb_s = bram_data;
    end else if (out_s.act) begin
      rgb_s = border_rgb;
    end else begin
      rgb_s = '0;
    end
  end

  assign bram_addr     = bram_addr_r;
  assign bram_en       = bram_en_r;
  assign hs            = out_s.hs;
  assign vs            = out_s.vs;
  assign active_nblank = out_s.act;
  assign draw_x        = out_s.dx;
  assign draw_y        = out_s.dy;
  assign frame_start   = out_s.fs;
  assign red           = rgb_s[PIX_W-1 -: 6];
  assign green         = rgb_s[PIX_W-7 -: 6];
  assign blue          = rgb_s[PIX_W-13 -: 6];

endmodule

// File: tb/tb_nds_window_scanout.sv
// Randomised bench: four scan-out instances on a small raster, each checked every cycle
// against a pixel-index model (divide/modulo on a linear pixel count since reset release).
module tb_nds_window_scanout;

  localparam int HA = 40, HFP = 4, HSY = 6, HBP = 6;
  localparam int VA = 30, VFP = 2, VSY = 2, VBP = 3;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;
  localparam int SW = 8, SH = 6;

  logic        clk;
  logic        reset;
  logic [17:0] border_rgb;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check_eq(input int inst, input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL g%0d %s @%0t got=%0h exp=%0h", inst, tag, $time, got, exp);
    end
  endtask

  function automatic logic [17:0] fmap(input logic [7:0] a);
    return {a, a ^ 8'hA5, 2'b10};
  endfunction

  function automatic bit in_win(input int hc, input int vc, input int x0, input int y0,
                                input int sc);
    return (hc >= x0) && (hc < x0 + SW * sc) && (vc >= y0) && (vc < y0 + SH * sc);
  endfunction

  function automatic int src_addr(input int hc, input int vc, input int x0, input int y0,
                                  input int sc);
    return ((vc - y0) / sc) * SW + (hc - x0) / sc;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    border_rgb = 18'd0;
    forever begin
      @(posedge clk);
      #1 border_rgb = 18'($urandom);
    end
  end

  for (genvar g = 0; g < 4; g++) begin : inst
    localparam int SC  = (g == 0) ? 1  : (g == 1) ? 2 : (g == 2) ? 4 : 3;
    localparam int X0  = (g == 0) ? 12 : (g == 1) ? 4 : (g == 2) ? 8 : 0;
    localparam int Y0  = (g == 0) ? 10 : (g == 1) ? 6 : (g == 2) ? 6 : 0;
    localparam int LAT = (g == 0) ? 2  : (g == 1) ? 1 : (g == 2) ? 3 : 2;
    localparam bit HP  = (g == 1) || (g == 3);
    localparam bit VP  = (g == 2) || (g == 3);

    logic [7:0]  bram_addr;
    logic        bram_en;
    logic [17:0] bram_data;
    logic        hs, vs, act, fs;
    logic [9:0]  dx, dy;
    logic [5:0]  r, gr, b;
    logic [17:0] q [1:LAT];
    int          kcnt;
    int          last_addr;

    nds_window_scanout #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .HS_POL(HP), .VS_POL(VP), .SRC_W(SW), .SRC_H(SH), .SCALE(SC),
      .WIN_X0(X0), .WIN_Y0(Y0), .PIX_W(18), .BRAM_LAT(LAT), .ADDR_W(8)
    ) dut (
      .pixel_clk(clk), .reset(reset), .border_rgb(border_rgb),
      .bram_addr(bram_addr), .bram_en(bram_en), .bram_data(bram_data),
      .hs(hs), .vs(vs), .active_nblank(act), .draw_x(dx), .draw_y(dy),
      .red(r), .green(gr), .blue(b), .frame_start(fs)
    );

    // Synchronous BRAM: data appears LAT cycles after the enable; unrequested reads return a marker.
    always @(posedge clk) begin
      q[1] <= bram_en ? fmap(bram_addr) : 18'h3ffff;
      for (int i = 2; i <= LAT; i++) q[i] <= q[i-1];
    end
    assign bram_data = q[LAT];

    always @(posedge clk or posedge reset) begin
      if (reset) kcnt <= 0;
      else       kcnt <= kcnt + 1;
    end

    always @(negedge clk) begin
      int p, pe, hc, vc, ehc, evc, ea;
      bit e_act, e_hs, e_vs, e_fs, e_win, e_en;
      logic [17:0] e_rgb;
      p  = kcnt - LAT - 1;
      pe = kcnt - 1;
      if (kcnt == 0) last_addr = 0;
      if (p < 0) begin
        e_act = 1'b0; e_hs = !HP; e_vs = !VP; e_fs = 1'b0; e_rgb = 18'd0; hc = 0; vc = 0;
      end else begin
        hc    = p % HT;
        vc    = (p / HT) % VT;
        e_act = (hc < HA) && (vc < VA);
        e_hs  = (hc >= HA + HFP && hc < HA + HFP + HSY) ? HP : !HP;
        e_vs  = (vc >= VA + VFP && vc < VA + VFP + VSY) ? VP : !VP;
        e_fs  = (p % FRAME) == 0;
        e_win = in_win(hc, vc, X0, Y0, SC);
        if (e_win)      e_rgb = fmap(8'(src_addr(hc, vc, X0, Y0, SC)));
        else if (e_act) e_rgb = border_rgb;
        else            e_rgb = 18'd0;
      end
      if (pe < 0) begin
        e_en = 1'b0;
      end else begin
        ehc  = pe % HT;
        evc  = (pe / HT) % VT;
        e_en = in_win(ehc, evc, X0, Y0, SC);
        if (e_en) begin
          ea = src_addr(ehc, evc, X0, Y0, SC);
          if (ea > SW * SH - 1) ea = -1;
          last_addr = ea;
        end
      end
      check_eq(g, "hs", 32'(hs), 32'(e_hs));
      check_eq(g, "vs", 32'(vs), 32'(e_vs));
      check_eq(g, "active_nblank", 32'(act), 32'(e_act));
      check_eq(g, "frame_start", 32'(fs), 32'(e_fs));
      check_eq(g, "rgb", 32'({r, gr, b}), 32'(e_rgb));
      check_eq(g, "bram_en", 32'(bram_en), 32'(e_en));
      check_eq(g, "bram_addr", 32'(bram_addr), 32'(last_addr));
      if (e_act || p < 0) check_eq(g, "draw_xy", 32'({dy, dx}), 32'({10'(vc), 10'(hc)}));
    end
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2 * FRAME + 20 * HT + 30) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (FRAME + 200) @(posedge clk);
    repeat ($urandom_range(1, FRAME)) @(posedge clk);
    #1 reset = 1'b1;
    repeat ($urandom_range(1, 4)) @(posedge clk);
    #1 reset = 1'b0;
    repeat (FRAME + 100) @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
